// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared states and constants for the instruction fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    FETCH2 = 3'd3,
    FETCH3 = 3'd4,
    VALID  = 3'd5
  } fetch_state_t;

  localparam int          INSTR_BYTES   = 4;
  localparam logic [1:0]  IO_REGION_TAG = 2'b11;
  localparam int          IO_TAG_MSB    = 7;
  localparam int          IO_TAG_LSB    = 6;
  localparam int          PC_RESET      = 0;

endpackage

// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - byte-lane shadow register with whole-word commit
// The committed word only changes on commit, so readers never see a partial instruction.
module instr_assembler #(
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_BYTES = 4,
  parameter int LANE_W      = $clog2(INSTR_BYTES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              wr_en,
  input  logic [LANE_W-1:0]                 lane_sel,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              commit,
  output logic [DATA_WIDTH*INSTR_BYTES-1:0] word
);

  localparam int WORD_W = DATA_WIDTH * INSTR_BYTES;

  logic [WORD_W-1:0] shadow;
  logic [WORD_W-1:0] shadow_next;

  always_comb begin
    shadow_next = shadow;
    if (wr_en) shadow_next[lane_sel*DATA_WIDTH +: DATA_WIDTH] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      word   <= '0;
    end else begin
      shadow <= clear ? '0 : shadow_next;
      // Commit merges the final lane written on this same edge.
      if (commit) word <= shadow_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC-owning byte fetch sequencer; optional IO_FETCH_GUARD_EN aborts fetches from the IO region
module fetch_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_BYTES = fetch_pkg::INSTR_BYTES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              pc_load,
  input  logic [ADDR_WIDTH-1:0]             pc_target,
  input  logic                              flush,
  input  logic                              ack,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [DATA_WIDTH-1:0]             mem_q,
  output logic [DATA_WIDTH*INSTR_BYTES-1:0] instr,
  output logic                              instr_valid,
  output logic                              busy,
  output logic [ADDR_WIDTH-1:0]             pc,
  output logic                              fault
);
  import fetch_pkg::*;

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [1:0]            lane_sel;
  logic                  in_fetch;
  logic                  io_hit;
  logic                  capture;
  logic                  commit;
  logic                  load_ok;

  always_comb begin
    in_fetch = (state == FETCH0) || (state == FETCH1) ||
               (state == FETCH2) || (state == FETCH3);
`ifdef IO_FETCH_GUARD_EN
    io_hit = in_fetch && (pc[IO_TAG_MSB:IO_TAG_LSB] == IO_REGION_TAG);
`else
    io_hit = 1'b0;
`endif
    case (state)
      FETCH1:  lane_sel = 2'd1;
      FETCH2:  lane_sel = 2'd2;
      FETCH3:  lane_sel = 2'd3;
      default: lane_sel = 2'd0;
    endcase
    capture = in_fetch && !flush && !io_hit;
    commit  = capture && (state == FETCH3);
    // pc_load is only honoured outside FETCH, or together with a flush.
    load_ok = pc_load && (!in_fetch || flush);

    pc_next = pc;
    if (load_ok)       pc_next = pc_target;
    else if (in_fetch) begin
      if (flush)        pc_next = base;
      else if (!io_hit) pc_next = pc + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= ADDR_WIDTH'(PC_RESET);
      mem_addr    <= ADDR_WIDTH'(PC_RESET);
      base        <= ADDR_WIDTH'(PC_RESET);
      busy        <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pc       <= pc_next;
      mem_addr <= pc_next;
      if (load_ok) fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH0;
            busy  <= 1'b1;
            base  <= pc_next;
          end
        end
        FETCH0, FETCH1, FETCH2, FETCH3: begin
          if (flush || io_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!flush) fault <= 1'b1;
          end else begin
            case (state)
              FETCH0:  state <= FETCH1;
              FETCH1:  state <= FETCH2;
              FETCH2:  state <= FETCH3;
              default: begin
                state       <= VALID;
                busy        <= 1'b0;
                instr_valid <= 1'b1;
              end
            endcase
          end
        end
        VALID: begin
          if (flush) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
          end else if (ack && start) begin
            state       <= FETCH0;
            instr_valid <= 1'b0;
            busy        <= 1'b1;
            base        <= pc_next;
          end else if (ack) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  instr_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .INSTR_BYTES(INSTR_BYTES),
    .LANE_W     (2)
  ) u_asm (
    .clk     (clk),
    .reset   (reset),
    .clear   (in_fetch && flush),
    .wr_en   (capture),
    .lane_sel(lane_sel),
    .wr_data (mem_q),
    .commit  (commit),
    .word    (instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        flush;
  logic        ack;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_q;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic [7:0]  pc;
  logic        fault;

  logic [7:0] mem [0:255];
  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .pc_load(pc_load),
    .pc_target(pc_target), .flush(flush), .ack(ack), .mem_addr(mem_addr),
    .mem_q(mem_q), .instr(instr), .instr_valid(instr_valid), .busy(busy),
    .pc(pc), .fault(fault)
  );

  always #5 clk = ~clk;

  // Memory model: address registered on the falling edge, data ready for the next rising edge.
  always @(negedge clk) mem_q <= mem[mem_addr];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h00] = 8'h20; mem[8'h01] = 8'h08; mem[8'h02] = 8'h00; mem[8'h03] = 8'h05;
    mem[8'h04] = 8'h11; mem[8'h05] = 8'h22; mem[8'h06] = 8'h33; mem[8'h07] = 8'h44;
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03; mem[8'h13] = 8'h04;
    mem[8'hBE] = 8'h9A; mem[8'hBF] = 8'hBC; mem[8'hC0] = 8'hDE; mem[8'hC1] = 8'hF0;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB;
    mem_q = 8'h00;
    reset = 1'b1; start = 1'b0; pc_load = 1'b0; pc_target = 8'h00; flush = 1'b0; ack = 1'b0;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_fault", fault, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b0;

    // Basic fetch from 0x00
    start = 1'b1; tick(); start = 1'b0;
    chk("f0_busy", busy, 1);
    chk("f0_addr", mem_addr, 8'h00);
    tick(3);
    chk("f3_not_valid", instr_valid, 0);
    chk("f3_pc", pc, 8'h03);
    tick();
    chk("i0_valid", instr_valid, 1);
    chk("i0_instr", instr, 32'h05000820);
    chk("i0_pc", pc, 8'h04);
    chk("i0_busy", busy, 0);

    // Back-to-back fetch with ack+start
    ack = 1'b1; start = 1'b1; tick(); ack = 1'b0; start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_valid", instr_valid, 0);
    tick(4);
    chk("i1_valid", instr_valid, 1);
    chk("i1_instr", instr, 32'h44332211);
    chk("i1_pc", pc, 8'h08);

    // start in VALID without ack is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("hold_valid", instr_valid, 1);
    chk("hold_busy", busy, 0);
    chk("hold_pc", pc, 8'h08);

    // Wrap fetch at 0xFE; pc_load during FETCH ignored
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_idle", instr_valid, 0);
    pc_load = 1'b1; pc_target = 8'hFE; tick(); pc_load = 1'b0;
    chk("load_pc", pc, 8'hFE);
    start = 1'b1; tick(); start = 1'b0;
    pc_load = 1'b1; pc_target = 8'h55; tick(); pc_load = 1'b0;
    chk("load_in_fetch_ignored", pc, 8'hFF);
    tick(3);
    chk("wrap_valid", instr_valid, 1);
    chk("wrap_instr", instr, 32'h0820BBAA);
    chk("wrap_pc", pc, 8'h02);

    // Flush after two FETCH cycles at base 0x10
    ack = 1'b1; tick(); ack = 1'b0;
    pc_load = 1'b1; pc_target = 8'h10; tick(); pc_load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(2);
    chk("pre_flush_pc", pc, 8'h12);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_pc", pc, 8'h10);
    chk("flush_valid", instr_valid, 0);
    chk("flush_instr", instr, 32'h0820BBAA);

    // Refetch 0x10, then flush+pc_load in VALID beats ack/start
    start = 1'b1; tick(); start = 1'b0;
    tick(4);
    chk("i2_instr", instr, 32'h04030201);
    chk("i2_pc", pc, 8'h14);
    flush = 1'b1; pc_load = 1'b1; pc_target = 8'h40; ack = 1'b1; start = 1'b1;
    tick();
    flush = 1'b0; pc_load = 1'b0; ack = 1'b0; start = 1'b0;
    chk("vflush_valid", instr_valid, 0);
    chk("vflush_busy", busy, 0);
    chk("vflush_pc", pc, 8'h40);

    // Reset during FETCH2
    start = 1'b1; tick(); start = 1'b0;
    tick(2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_addr", mem_addr, 0);

    // Fetch crossing into the IO region at 0xC0
    pc_load = 1'b1; pc_target = 8'hBE; tick(); pc_load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(3);
`ifdef IO_FETCH_GUARD_EN
    chk("io_fault", fault, 1);
    chk("io_valid", instr_valid, 0);
    chk("io_busy", busy, 0);
    chk("io_instr", instr, 0);
    pc_load = 1'b1; pc_target = 8'h00; tick(); pc_load = 1'b0;
    chk("io_fault_clear", fault, 0);
`else
    chk("io_fault", fault, 0);
    chk("io_busy", busy, 1);
    tick();
    chk("io_valid", instr_valid, 1);
    chk("io_instr", instr, 32'hF0DEBC9A);
    chk("io_pc", pc, 8'hC2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
